// File: rtl/loop_addr_linearizer.sv
// Flattens a 4-deep loop index tuple into a buffer address: base + sum(idx_k * stride_k).
// Two-stage valid/ready pipeline with per-beat range check, end-of-nest flag and beat counter.
module loop_addr_linearizer #(
  parameter int IDX_W  = 16,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  in_i0,
  input  logic [IDX_W-1:0]  in_i1,
  input  logic [IDX_W-1:0]  in_i2,
  input  logic [IDX_W-1:0]  in_i3,
  input  logic [IDX_W-1:0]  dim0,
  input  logic [IDX_W-1:0]  dim1,
  input  logic [IDX_W-1:0]  dim2,
  input  logic [IDX_W-1:0]  dim3,
  input  logic [ADDR_W-1:0] stride0,
  input  logic [ADDR_W-1:0] stride1,
  input  logic [ADDR_W-1:0] stride2,
  input  logic [ADDR_W-1:0] stride3,
  input  logic [ADDR_W-1:0] base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              out_last,
  output logic [CNT_W-1:0]  beat_cnt
);

  logic [IDX_W-1:0]  idx_s    [4];
  logic [IDX_W-1:0]  dim_s    [4];
  logic [ADDR_W-1:0] stride_s [4];

  logic [ADDR_W-1:0] prod_d   [4];
  logic              err1_d;
  logic              last1_d;

  logic              v1_q, v1_d;
  logic [ADDR_W-1:0] prod_q   [4];
  logic [ADDR_W-1:0] base_q;
  logic              err1_q;
  logic              last1_q;

  logic              v2_q, v2_d;
  logic [ADDR_W-1:0] addr_q;
  logic              err2_q;
  logic              last2_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              s2_adv_s;
  logic              in_hs_s;
  logic              out_hs_s;
  logic [ADDR_W-1:0] sum_s;

  assign idx_s    = '{in_i0, in_i1, in_i2, in_i3};
  assign dim_s    = '{dim0, dim1, dim2, dim3};
  assign stride_s = '{stride0, stride1, stride2, stride3};

  assign s2_adv_s = ~v2_q | out_ready;
  assign in_ready = ~v1_q | s2_adv_s;
  assign in_hs_s  = in_valid & in_ready;
  assign out_hs_s = v2_q & out_ready;

  // Per-loop products and range flags; last is masked by err so a zero dim never reports last.
  always_comb begin
    err1_d  = 1'b0;
    last1_d = 1'b1;
    for (int k = 0; k < 4; k++) begin
      prod_d[k] = ADDR_W'(idx_s[k]) * stride_s[k];
      err1_d    = err1_d | (idx_s[k] >= dim_s[k]);
      last1_d   = last1_d & (idx_s[k] == (dim_s[k] - IDX_W'(1)));
    end
    last1_d = last1_d & ~err1_d;
  end

  // Valid-bit next state for both stages.
  always_comb begin
    if (in_hs_s) begin
      v1_d = 1'b1;
    end else if (s2_adv_s) begin
      v1_d = 1'b0;
    end else begin
      v1_d = v1_q;
    end
    if (s2_adv_s) begin
      v2_d = v1_q;
    end else begin
      v2_d = v2_q;
    end
  end

  assign sum_s = base_q + prod_q[0] + prod_q[1] + prod_q[2] + prod_q[3];

  // Stage 1: capture products and config-derived flags on input handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      base_q  <= '0;
      err1_q  <= 1'b0;
      last1_q <= 1'b0;
      for (int k = 0; k < 4; k++) prod_q[k] <= '0;
    end else begin
      v1_q <= v1_d;
      if (in_hs_s) begin
        base_q  <= base;
        err1_q  <= err1_d;
        last1_q <= last1_d;
        for (int k = 0; k < 4; k++) prod_q[k] <= prod_d[k];
      end
    end
  end

  // Stage 2: output register, held while stalled; beat counter saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q    <= 1'b0;
      addr_q  <= '0;
      err2_q  <= 1'b0;
      last2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      v2_q <= v2_d;
      if (s2_adv_s && v1_q) begin
        addr_q  <= sum_s;
        err2_q  <= err1_q;
        last2_q <= last1_q;
      end
      if (out_hs_s && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = v2_q;
  assign out_addr  = addr_q;
  assign out_err   = err2_q;
  assign out_last  = last2_q;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_loop_addr_linearizer.sv
// Directed bench for loop_addr_linearizer: vector table, full nest sweep,
// backpressure, wrap and async reset sequences.
module tb_loop_addr_linearizer;
  localparam int IDX_W  = 16;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 32;
  localparam int NEST   = 16 * 4 * 392 * 3;

  typedef struct packed {
    logic [3:0][15:0] idx;
    logic [3:0][15:0] dim;
    logic [3:0][31:0] str;
    logic [31:0]      base;
    logic [31:0]      exp_addr;
    logic             exp_err;
    logic             exp_last;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready, out_err, out_last;
  logic [IDX_W-1:0]  in_i0, in_i1, in_i2, in_i3, dim0, dim1, dim2, dim3;
  logic [ADDR_W-1:0] stride0, stride1, stride2, stride3, base, out_addr;
  logic [CNT_W-1:0]  beat_cnt;

  int checks = 0;
  int failures = 0;
  int exp_beats = 0;
  vec_t vecs [8];

  always #5 clk = ~clk;

  loop_addr_linearizer #(.IDX_W(IDX_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_i0(in_i0), .in_i1(in_i1), .in_i2(in_i2), .in_i3(in_i3),
    .dim0(dim0), .dim1(dim1), .dim2(dim2), .dim3(dim3),
    .stride0(stride0), .stride1(stride1), .stride2(stride2), .stride3(stride3),
    .base(base), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_err(out_err), .out_last(out_last), .beat_cnt(beat_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_i0 = v.idx[0]; in_i1 = v.idx[1]; in_i2 = v.idx[2]; in_i3 = v.idx[3];
    dim0 = v.dim[0]; dim1 = v.dim[1]; dim2 = v.dim[2]; dim3 = v.dim[3];
    stride0 = v.str[0]; stride1 = v.str[1]; stride2 = v.str[2]; stride3 = v.str[3];
    base = v.base;
  endtask

  task automatic set_tuple(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
    in_i0 = a; in_i1 = b; in_i2 = c; in_i3 = d;
  endtask

  task automatic conv_cfg();
    base = 32'd0;
    stride0 = 32'd1; stride1 = 32'd16; stride2 = 32'd64; stride3 = 32'd25088;
    dim0 = 16'd16; dim1 = 16'd4; dim2 = 16'd392; dim3 = 16'd3;
  endtask

  // One beat with no backpressure; config is scrambled right after capture.
  task automatic apply_vec(input vec_t v, input string name);
    @(negedge clk);
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    base = ~base; stride0 = ~stride0; stride3 = 32'h1234_5678;
    dim0 = 16'd0; in_i0 = ~in_i0;
    check({name, "_lat1_valid"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_addr"}, 64'(out_addr), 64'(v.exp_addr));
    check({name, "_err"}, 64'(out_err), 64'(v.exp_err));
    check({name, "_last"}, 64'(out_last), 64'(v.exp_last));
    exp_beats++;
    @(negedge clk);
    check({name, "_drained"}, 64'(out_valid), 64'd0);
    check({name, "_beat_cnt"}, 64'(beat_cnt), 64'(exp_beats));
  endtask

  initial begin
    logic [31:0] got [$];
    int bad, stalls, lasts, m;
    logic accepted;

    vecs[0] = '{{16'd1, 16'd10, 16'd2, 16'd5}, {16'd3, 16'd392, 16'd4, 16'd16},
                {32'd25088, 32'd64, 32'd16, 32'd1}, 32'd4096, 32'd29861, 1'b0, 1'b0};
    vecs[1] = '{{16'd0, 16'd0, 16'd0, 16'd16}, {16'd3, 16'd392, 16'd4, 16'd16},
                {32'd25088, 32'd64, 32'd16, 32'd1}, 32'd4096, 32'd4112, 1'b1, 1'b0};
    vecs[2] = '{{16'd2, 16'd391, 16'd3, 16'd15}, {16'd3, 16'd392, 16'd4, 16'd16},
                {32'd25088, 32'd64, 32'd16, 32'd1}, 32'd4096, 32'd79359, 1'b0, 1'b1};
    vecs[3] = '{{16'd0, 16'd0, 16'd0, 16'd32}, {16'd1, 16'd1, 16'd1, 16'd64},
                {32'd0, 32'd0, 32'd0, 32'd1}, 32'hFFFF_FFF0, 32'h0000_0010, 1'b0, 1'b0};
    vecs[4] = '{{16'd0, 16'd0, 16'd0, 16'd0}, {16'd1, 16'd1, 16'd1, 16'd0},
                {32'd4, 32'd3, 32'd2, 32'd1}, 32'd100, 32'd100, 1'b1, 1'b0};
    vecs[5] = '{{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, {16'd0, 16'd0, 16'd0, 16'd0},
                {32'd0, 32'd0, 32'd0, 32'd1}, 32'd0, 32'h0000_FFFF, 1'b1, 1'b0};
    vecs[6] = '{{16'hFFFF, 16'd0, 16'd0, 16'd0}, {16'hFFFF, 16'd1, 16'd1, 16'd1},
                {32'h0001_0001, 32'd0, 32'd0, 32'd0}, 32'd1, 32'd0, 1'b1, 1'b0};
    vecs[7] = '{{16'd2, 16'd0, 16'd1, 16'd3}, {16'd3, 16'd1, 16'd2, 16'd4},
                {32'h0001_0000, 32'd1000, 32'd100, 32'd8}, 32'h20, 32'd131228, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_tuple(16'd0, 16'd0, 16'd0, 16'd0);
    conv_cfg();
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_addr", 64'(out_addr), 64'd0);
    check("post_rst_err", 64'(out_err), 64'd0);
    check("post_rst_last", 64'(out_last), 64'd0);

    for (int i = 0; i < 8; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Full nest sweep, back to back; output of tuple k-2 is visible at negedge k.
    conv_cfg();
    out_ready = 1'b1;
    bad = 0; stalls = 0; lasts = 0;
    for (int k = 0; k <= NEST + 1; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        m = k - 2;
        if (out_valid !== 1'b1 || out_addr !== 32'(m) || out_err !== 1'b0 ||
            out_last !== (m == NEST - 1)) bad++;
      end
      if (out_valid === 1'b1 && out_last === 1'b1) lasts++;
      if (k < NEST) begin
        if (in_ready !== 1'b1) stalls++;
        set_tuple(16'(k % 16), 16'((k / 16) % 4), 16'((k / 64) % 392), 16'(k / 25088));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    exp_beats += NEST;
    @(negedge clk);
    check("sweep_bad_beats", 64'(bad), 64'd0);
    check("sweep_stalls", 64'(stalls), 64'd0);
    check("sweep_last_count", 64'(lasts), 64'd1);
    check("sweep_beat_cnt", 64'(beat_cnt), 64'(exp_beats));

    // Backpressure: out_ready low for 5 cycles while offering 3 tuples.
    conv_cfg();
    out_ready = 1'b0;
    set_tuple(16'd1, 16'd0, 16'd0, 16'd0); in_valid = 1'b1;
    check("bp_ready_a", 64'(in_ready), 64'd1);
    @(negedge clk);
    set_tuple(16'd2, 16'd0, 16'd0, 16'd0);
    check("bp_ready_b", 64'(in_ready), 64'd1);
    @(negedge clk);
    set_tuple(16'd0, 16'd1, 16'd0, 16'd0);
    check("bp_stall_ready", 64'(in_ready), 64'd0);
    check("bp_stall_valid", 64'(out_valid), 64'd1);
    check("bp_stall_addr", 64'(out_addr), 64'd1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_ready", c), 64'(in_ready), 64'd0);
      check($sformatf("bp_hold%0d_addr", c), 64'(out_addr), 64'd1);
      check($sformatf("bp_hold%0d_valid", c), 64'(out_valid), 64'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 8; c++) begin
      accepted = in_valid & in_ready;
      if (out_valid === 1'b1) got.push_back(out_addr);
      @(negedge clk);
      if (accepted) in_valid = 1'b0;
    end
    check("bp_count", 64'(got.size()), 64'd3);
    check("bp_first", 64'((got.size() > 0) ? got[0] : 32'hDEAD_BEEF), 64'd1);
    check("bp_second", 64'((got.size() > 1) ? got[1] : 32'hDEAD_BEEF), 64'd2);
    check("bp_third", 64'((got.size() > 2) ? got[2] : 32'hDEAD_BEEF), 64'd16);
    exp_beats += 3;
    check("bp_beat_cnt", 64'(beat_cnt), 64'(exp_beats));

    // Async reset with both stages full.
    out_ready = 1'b0;
    set_tuple(16'd3, 16'd0, 16'd0, 16'd0); in_valid = 1'b1;
    @(negedge clk);
    set_tuple(16'd4, 16'd0, 16'd0, 16'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("ar_full_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid_drop", 64'(out_valid), 64'd0);
    check("ar_beat_cnt", 64'(beat_cnt), 64'd0);
    check("ar_addr", 64'(out_addr), 64'd0);
    check("ar_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_beats = 0;
    apply_vec(vecs[0], "ar_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/loop_addr_linearizer.md
Name: loop_addr_linearizer

Overview:
- Inverse of the cascaded loop-index counter chain. The chain turns one enable stream into nested indices (i0 innermost .. i3 outermost); this block takes an index tuple and produces the flat buffer address.
- Sits between the loop-nest index generator and the activation/weight buffer read port.
- Computes the linear address from runtime base and strides.
- 2-stage elastic pipeline with valid/ready backpressure, per-beat range check, end-of-nest flag and a beat counter.

Parameters:
- IDX_W, 16, width of each loop index and dimension size
- ADDR_W, 32, width of base, strides, address
- CNT_W, 32, width of the accepted-beat counter

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  index tuple valid
- in_ready  output  1  block can accept tuple
- in_i0..in_i3  input  IDX_W each  loop indices, i0 innermost
- dim0..dim3  input  IDX_W each  loop sizes (legal index range 0..dimk-1)
- stride0..stride3  input  ADDR_W each  address stride per loop
- base  input  ADDR_W  base address
- out_valid  output  1  address valid
- out_ready  input  1  downstream accepts address
- out_addr  output  ADDR_W  linear address
- out_err  output  1  at least one index out of range on this beat
- out_last  output  1  tuple is final point of the nest
- beat_cnt  output  CNT_W  number of output handshakes since reset

Behaviour:
- Reset (async, rst=1): v1=v2=0, out_valid=0, out_addr=0, out_err=0, out_last=0, beat_cnt=0. A reset mid-operation discards all in-flight beats. in_ready=1 after reset.
- Handshakes:
  - Input handshake = in_valid & in_ready.
  - Output handshake = out_valid & out_ready.
  - out_valid, out_addr, out_err and out_last hold stable while out_valid=1 and out_ready=0.
- Stage 1, on input handshake, captures:
  - products pk = in_ik * stridek, each truncated to ADDR_W;
  - base;
  - err1 = OR over k of (in_ik >= dimk);
  - last1 = AND over k of (in_ik == dimk-1).
  - Sets v1=1.
- Stage 2: when it advances from a valid stage 1:
  - out_addr = base + p0 + p1 + p2 + p3, modulo 2^ADDR_W (wrap, no saturation);
  - err and last copied through.
- Pipeline control:
  - s2_adv = ~v2 | out_ready;
  - in_ready = ~v1 | s2_adv (combinational, no bubble at full throughput);
  - v1 next = input handshake ? 1 : (s2_adv ? 0 : v1);
  - v2 next = s2_adv ? v1 : v2.
- Latency: 2 cycles from input handshake to out_valid=1 with no backpressure. Throughput: 1 beat/cycle.
- Configuration timing: dim, stride and base are sampled only at the stage-1 capture of each beat. Changing them affects only later-accepted beats.
- dimk=0 makes every index out of range: err=1 and last=0 for any tuple.
- Out-of-range beats still produce an address (computed normally) with out_err=1. They are never dropped.
- Simultaneous input and output handshake with both stages full: both stages shift and the new tuple enters stage 1. No loss, no duplication.
- beat_cnt increments on each output handshake and saturates at 2^CNT_W-1.

Test Plan:
- Reset, then single tuple: base=4096, strides (1,16,64,25088), tuple (5,2,10,1), dims (16,4,392,3), out_ready=1 -> 2 cycles later out_addr=29861, err=0, last=0, beat_cnt=1.
- Full nest sweep: drive all 16*4*392*3=75264 tuples in loop order, back-to-back, base=0, same strides -> addresses 0..75263 consecutive. Only the final beat (15,3,391,2) has last=1 and addr=75263. beat_cnt=75264, never stalls.
- Range error: tuple (16,0,0,0) -> out_err=1, addr=base+16. Tuple (15,3,391,2) -> err=0, last=1.
- Backpressure: hold out_ready=0 for 5 cycles while sending 3 tuples -> in_ready drops after 2 are accepted; out_addr stable. Release -> all 3 emerge in order, no duplicates.
- Wrap: base=0xFFFFFFF0, stride0=1, tuple (32,0,0,0), dim0=64 -> out_addr=0x00000010.
- Async reset mid-flight: assert rst with both stages full -> out_valid falls immediately (no clock edge), beat_cnt=0. After release the next tuple has 2-cycle latency.
